// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV_ITER = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// rtl/muldiv_unit_div_iter.sv - radix-2 restoring divider datapath on magnitudes
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             is_signed_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    // The partial remainder always ends below the divisor, so it fits WIDTH
    // bits; the trial difference carries the extra borrow bit.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
    logic [WIDTH:0]   rem_sh, trial;
    logic             qbit;

    assign a_abs = (is_signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign b_abs = (is_signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

    // The load cycle already produces the first quotient bit (counter value 0),
    // so the remaining WIDTH-1 bits come from step cycles.
    assign src_rem = load_i ? '0    : rem_q;
    assign src_quo = load_i ? a_abs : quo_q;
    assign src_dvs = load_i ? b_abs : dvs_q;

    assign rem_sh = {src_rem, src_quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, src_dvs};
    assign qbit   = ~trial[WIDTH];

    // Next-state for the shift registers and iteration counter
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_d = {src_quo[WIDTH-2:0], qbit};
            dvs_d = b_abs;
            cnt_d = CW'(1);
        end else if (step_i) begin
            rem_d = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_d = {src_quo[WIDTH-2:0], qbit};
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign quot_o = quo_q;
    assign rem_o  = rem_q;
    assign done_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply/divide unit for EX
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               annul,
    output logic               stall,
    output logic               valid,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    localparam int MCW        = $clog2(MUL_CYCLES + 1);
    localparam int PIPE_DEPTH = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
    localparam int PIPE_LAST  = PIPE_DEPTH - 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    md_op_e    op_e;
    md_state_e state_q, state_d;
    logic [MCW-1:0]       mul_cnt_q, mul_cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 dz_q, dz_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   mul_pipe_q [PIPE_DEPTH];

    logic                 ready, accept, sgn;
    logic [2*WIDTH-1:0]   ext_a, ext_b, mul_prod, mul_last, div_res;
    logic                 div_load, div_step, div_done;
    logic [WIDTH-1:0]     div_quo, div_rem, quo_fix, rem_fix;

    assign op_e   = md_op_e'(op);
    assign sgn    = op_is_signed(op_e);
    assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept = start & ready & ~annul;

    // Full-width product of the extended operands; no truncation
    assign ext_a    = {{WIDTH{sgn & num1[WIDTH-1]}}, num1};
    assign ext_b    = {{WIDTH{sgn & num2[WIDTH-1]}}, num2};
    assign mul_prod = ext_a * ext_b;
    assign mul_last = (MUL_CYCLES == 1) ? mul_prod : mul_pipe_q[PIPE_LAST];

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .load_i      (div_load),
        .step_i      (div_step),
        .dividend_i  (num1),
        .divisor_i   (num2),
        .is_signed_i (sgn),
        .quot_o      (div_quo),
        .rem_o       (div_rem),
        .done_o      (div_done)
    );

    // Sign correction and the two defined special cases
    assign quo_fix = q_neg_q ? -div_quo : div_quo;
    assign rem_fix = r_neg_q ? -div_rem : div_rem;
    assign div_res = dz_q  ? {a_raw_q, ALL_ONES} :
                     ovf_q ? {{WIDTH{1'b0}}, a_raw_q} :
                             {rem_fix, quo_fix};

    // Next-state, result capture and divider control
    always_comb begin
        state_d    = state_q;
        mul_cnt_d  = mul_cnt_q;
        result_d   = result_q;
        div_zero_d = 1'b0;
        a_raw_d    = a_raw_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        div_load   = 1'b0;
        div_step   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (op_is_div(op_e)) begin
                        state_d  = ST_DIV_ITER;
                        div_load = 1'b1;
                        a_raw_d  = num1;
                        q_neg_d  = sgn & (num1[WIDTH-1] ^ num2[WIDTH-1]);
                        r_neg_d  = sgn & num1[WIDTH-1];
                        dz_d     = (num2 == '0);
                        ovf_d    = sgn & (num1 == MOST_NEG) & (num2 == ALL_ONES);
                    end else if (MUL_CYCLES == 1) begin
                        state_d  = ST_DONE;
                        result_d = mul_prod;
                    end else begin
                        state_d   = ST_MUL;
                        mul_cnt_d = MCW'(1);
                    end
                end
            end
            ST_MUL: begin
                if (annul) begin
                    state_d = ST_IDLE;
                end else if (mul_cnt_q == MCW'(MUL_CYCLES - 1)) begin
                    state_d  = ST_DONE;
                    result_d = mul_last;
                end else begin
                    mul_cnt_d = mul_cnt_q + MCW'(1);
                end
            end
            ST_DIV_ITER: begin
                if (annul) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (div_done) begin
                        state_d = ST_DIV_FIX;
                    end
                end
            end
            ST_DIV_FIX: begin
                if (annul) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_DONE;
                    result_d   = div_res;
                    div_zero_d = dz_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mul_cnt_q  <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            a_raw_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mul_cnt_q  <= mul_cnt_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            a_raw_q    <= a_raw_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    // Free-running product pipeline; the result register forms its last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                mul_pipe_q[i] <= '0;
            end
        end else begin
            mul_pipe_q[0] <= mul_prod;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                mul_pipe_q[i] <= mul_pipe_q[i-1];
            end
        end
    end

    assign stall    = accept | (~annul & ((state_q == ST_MUL) ||
                                          (state_q == ST_DIV_ITER) ||
                                          (state_q == ST_DIV_FIX)));
    assign valid    = (state_q == ST_DONE);
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int MC = 2;

    logic           clk = 1'b0;
    logic           rst, start, annul;
    logic [1:0]     op;
    logic [W-1:0]   num1, num2;
    logic           stall, valid, div_zero;
    logic [2*W-1:0] result;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .num1     (num1),
        .num2     (num2),
        .annul    (annul),
        .stall    (stall),
        .valid    (valid),
        .result   (result),
        .div_zero (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {div_zero, result} from plain integer arithmetic
    function automatic logic [2*W:0] ref_op(input logic [1:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (o)
            2'd0: return {1'b0, 64'(sa * sb)};
            2'd1: return {1'b0, 64'(ua * ub)};
            default: begin
                if (b == 0) return {1'b1, a, {W{1'b1}}};
                if (o == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, a};
                    q = sa / sb;
                    r = sa % sb;
                    return {1'b0, r[31:0], q[31:0]};
                end
                return {1'b0, 32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Present a request at a negedge; it must be accepted in this cycle
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        num1  = a;
        num2  = b;
        start = 1'b1;
        #1;
        chk("stall_cycle0", stall, 1);
        @(posedge clk);
    endtask

    // Count cycles to valid, then check latency, result and flag
    task automatic wait_done(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b);
        int cyc;
        bit got;
        logic [2*W:0] exp;
        int exp_lat;
        exp     = ref_op(o, a, b);
        exp_lat = o[1] ? W + 1 : MC;
        cyc = 0;
        got = 0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (valid) got = 1;
            else if (stall !== 1'b1) chk({tag, "_stall_busy"}, stall, 1);
        end
        chk({tag, "_got_valid"}, got, 1);
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_result"}, result, exp[2*W-1:0]);
        chk({tag, "_div_zero"}, div_zero, exp[2*W]);
        chk({tag, "_stall_done"}, stall, 0);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        issue(o, a, b);
        wait_done(tag, o, a, b);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] prev;
        logic [1:0]     ro;
        logic [W-1:0]   ra, rb;
        int             mode;

        rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'd0; num1 = '0; num2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_valid", valid, 0);
        chk("reset_div_zero", div_zero, 0);
        chk("reset_result", result, 0);

        // Directed operations from the test plan
        do_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg3x5_const", result, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", result, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        do_op("divu_100_7", 2'd3, 32'd100, 32'd7);
        chk("divu_100_7_const", result, {32'd2, 32'd14});
        @(negedge clk);
        do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_const", result, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        do_op("div_by_zero", 2'd2, 32'h1234_5678, 32'd0);
        chk("div_by_zero_const", result, 64'h1234_5678_FFFF_FFFF);
        @(negedge clk);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", result, 64'h0000_0000_8000_0000);

        // Back-to-back: each start lands in the previous DONE cycle
        do_op("b2b_multu", 2'd1, 32'd3, 32'd4);
        do_op("b2b_divu", 2'd3, 32'd1000, 32'd10);
        do_op("b2b_mult", 2'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        @(negedge clk);

        // Annul a divide in cycle 10; a multiply accepted in cycle 11
        prev = result;
        issue(2'd3, 32'd123456, 32'd789);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) annul = 1'b1;
        end
        #1;
        chk("annul_stall_drop", stall, 0);
        @(negedge clk);
        annul = 1'b0;
        chk("annul_no_valid", valid, 0);
        chk("annul_result_kept", result, prev);
        chk("annul_idle_stall", stall, 0);
        do_op("after_annul_mult", 2'd0, 32'd7, 32'hFFFF_FFFA);
        watch_quiet("annul_no_stray_valid", 40);

        // start together with annul is not accepted
        op = 2'd0; num1 = 32'd9; num2 = 32'd9; start = 1'b1; annul = 1'b1;
        #1;
        chk("start_annul_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        chk("start_annul_stall_next", stall, 0);
        watch_quiet("start_annul_no_valid", 5);

        // Reset in cycle 5 of a divide
        issue(2'd2, 32'hFFFF_FC18, 32'd3);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_stall", stall, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_div_zero", div_zero, 0);
        chk("midrst_result", result, 0);
        watch_quiet("midrst_no_valid", 40);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
